flash_op_sequencer: RTL and testbench
=====================================

FLASH_OP_SEQUENCER -- requirements
Module: flash_op_sequencer

Interface
REQ-001 SHALL have parameter POLL_MAX, default 20'd1000000, max RDSR polls before timeout.
REQ-002 SHALL have parameter WIP_BIT, default 0, status-register bit index of write-in-progress.
REQ-003 clk  input  1  single clock, all logic on posedge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  host requests an operation.
REQ-006 req_cmd  input  5  host command input code (shared command input-code set).
REQ-007 req_ready  output  1  sequencer idle, accepts request.
REQ-008 op_done  output  1  one-cycle pulse, operation finished.
REQ-009 op_error  output  1  valid with op_done; 1 = poll timeout.
REQ-010 xfer_valid  output  1  issue one flash transaction to engine.
REQ-011 xfer_cmd  output  5  command input code for the transaction; feeds the command parser.
REQ-012 xfer_ready  input  1  engine accepts transaction.
REQ-013 xfer_done  input  1  one-cycle pulse, engine transaction complete.
REQ-014 xfer_status  input  8  status byte returned by RDSR, valid with xfer_done.

Function
REQ-015 Request handshake SHALL complete when req_valid && req_ready; req_cmd SHALL be latched into cmd_q that cycle.
REQ-016 req_ready SHALL be 1 only in IDLE.
REQ-017 Op classes: WRITE = PP, SE, BE, BE_64k, CE, WRSR, QPP, WRCR; RESET = RST_EN, RST; SIMPLE = all other codes.
REQ-018 States: IDLE, WREN, OP, POLL, RSTEN, RST, FIN.
REQ-019 From IDLE on accept: WRITE -> WREN; RESET -> RSTEN; SIMPLE -> OP.
REQ-020 Each issuing state SHALL hold xfer_valid=1 with a stable xfer_cmd until xfer_ready, then deassert xfer_valid and wait for xfer_done.
REQ-021 xfer_cmd: WREN state = WREN code; OP = cmd_q; POLL = RDSR code; RSTEN = RST_EN code; RST = RST code.
REQ-022 WREN done -> OP; OP done -> POLL if WRITE, else FIN; RSTEN done -> RST; RST done -> FIN.
REQ-023 POLL: on xfer_done with xfer_status[WIP_BIT]=0 -> FIN, op_error=0; with WIP=1, poll_cnt+1 and reissue RDSR next cycle.
REQ-024 poll_cnt SHALL be 20 bits, cleared on POLL entry; when poll_cnt reaches POLL_MAX with WIP still 1 -> FIN with op_error=1; no wrap-around.
REQ-025 FIN SHALL last exactly one cycle, pulse op_done, then -> IDLE; op_error SHALL be 0 except in FIN.
REQ-026 At most one transaction outstanding; xfer_done outside a wait phase SHALL be ignored.
REQ-027 xfer_done in the same cycle as xfer_ready SHALL count as completion.
REQ-028 req_valid while busy SHALL be ignored (no accept, no queuing).
REQ-029 Minimum latency SIMPLE accept to op_done: 3 cycles with xfer_ready and xfer_done each arriving in the first cycle allowed.

Reset
REQ-030 reset SHALL force IDLE, req_ready=1, xfer_valid=0, op_done=0, op_error=0, xfer_cmd=0, cmd_q=0, poll_cnt=0, effective on the next clk edge.
REQ-031 reset mid-operation SHALL abandon the operation with no op_done pulse; a subsequent late xfer_done SHALL be ignored.

Structure
REQ-032 State enum, op-class function and WREN/RDSR/RST_EN/RST input codes SHALL reside in the shared command package beside the existing command input codes.
REQ-033 Single module; no sub-module; the command parser is instantiated by the integrating top, not here.

Verification
REQ-034 SIMPLE JEDEC, xfer_ready/xfer_done immediate -> one xfer_cmd=JEDEC, op_done after 3 cycles, op_error=0.
REQ-035 PP, status returns 0x01, 0x01, 0x00 -> sequence WREN, PP, RDSR x3, op_done, op_error=0.
REQ-036 SE with POLL_MAX=4, status always 0x01 -> 4 RDSR polls then op_done with op_error=1.
REQ-037 RST request -> RST_EN then RST issued, op_done once, no RDSR.
REQ-038 reset asserted during POLL -> next cycle IDLE, req_ready=1, no op_done; a late xfer_done is ignored.
REQ-039 xfer_ready held 0 for 5 cycles in OP -> xfer_valid and xfer_cmd stable all 5 cycles; req_valid pulses meanwhile not accepted.

Source files
------------

// File: rtl/flash_op_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : flash_op_sequencer_pkg
// Description : Shared flash command input codes, sequencer states and the
//               op-class helper used by the command sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package flash_op_sequencer_pkg;

    typedef logic [4:0] cmd_t;

    localparam cmd_t c_CMD_READ   = 5'h00;
    localparam cmd_t c_CMD_FREAD  = 5'h01;
    localparam cmd_t c_CMD_PP     = 5'h02;
    localparam cmd_t c_CMD_SE     = 5'h03;
    localparam cmd_t c_CMD_BE     = 5'h04;
    localparam cmd_t c_CMD_BE_64K = 5'h05;
    localparam cmd_t c_CMD_CE     = 5'h06;
    localparam cmd_t c_CMD_WRSR   = 5'h07;
    localparam cmd_t c_CMD_QPP    = 5'h08;
    localparam cmd_t c_CMD_WRCR   = 5'h09;
    localparam cmd_t c_CMD_RDSR   = 5'h0A;
    localparam cmd_t c_CMD_WREN   = 5'h0B;
    localparam cmd_t c_CMD_RST_EN = 5'h0C;
    localparam cmd_t c_CMD_RST    = 5'h0D;
    localparam cmd_t c_CMD_JEDEC  = 5'h0E;
    localparam cmd_t c_CMD_RDCR   = 5'h0F;

    typedef logic [2:0] state_t;

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_WREN  = 3'd1;
    localparam logic [2:0] c_ST_OP    = 3'd2;
    localparam logic [2:0] c_ST_POLL  = 3'd3;
    localparam logic [2:0] c_ST_RSTEN = 3'd4;
    localparam logic [2:0] c_ST_RST   = 3'd5;
    localparam logic [2:0] c_ST_FIN   = 3'd6;

    typedef enum logic [1:0] {
        OPC_SIMPLE = 2'd0,
        OPC_WRITE  = 2'd1,
        OPC_RESET  = 2'd2
    } op_class_t;

    function automatic op_class_t op_class(input cmd_t cmd);
        op_class_t cls;
        cls = OPC_SIMPLE;
        case (cmd)
            c_CMD_PP, c_CMD_SE, c_CMD_BE, c_CMD_BE_64K,
            c_CMD_CE, c_CMD_WRSR, c_CMD_QPP, c_CMD_WRCR: cls = OPC_WRITE;
            c_CMD_RST_EN, c_CMD_RST:                     cls = OPC_RESET;
            default:                                     cls = OPC_SIMPLE;
        endcase
        return cls;
    endfunction

endpackage
`default_nettype wire

// File: rtl/flash_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : flash_op_sequencer
// Description : Expands a host flash request into WREN / op / RDSR-poll or
//               RST_EN / RST transaction sequences towards the flash engine.
// Revision    : 1.0 - initial release
// ============================================================================
module flash_op_sequencer
    import flash_op_sequencer_pkg::*;
#(
    parameter logic [19:0] POLL_MAX = 20'd1000000,
    parameter int          WIP_BIT  = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [4:0] req_cmd,
    output logic       req_ready,
    output logic       op_done,
    output logic       op_error,
    output logic       xfer_valid,
    output logic [4:0] xfer_cmd,
    input  logic       xfer_ready,
    input  logic       xfer_done,
    input  logic [7:0] xfer_status
);

    localparam logic [2:0] c_WIP_IDX = WIP_BIT[2:0];

    logic [2:0]  r_state;
    logic [4:0]  r_cmd_q;
    logic        r_issued;
    logic [19:0] r_poll_cnt;
    logic        r_err;

    logic        w_issuing;
    logic        w_xfer_complete;
    logic        w_wip;
    logic [19:0] w_poll_next;

    assign w_issuing = (r_state == c_ST_WREN) || (r_state == c_ST_OP) ||
                       (r_state == c_ST_POLL) || (r_state == c_ST_RSTEN) ||
                       (r_state == c_ST_RST);

    // A done pulse only counts once the transaction has been handed over,
    // which includes the cycle in which it is being accepted.
    assign w_xfer_complete = w_issuing &&
                             (r_issued ? xfer_done : (xfer_ready && xfer_done));

    assign w_wip       = xfer_status[c_WIP_IDX];
    assign w_poll_next = r_poll_cnt + 20'd1;

    assign req_ready  = (r_state == c_ST_IDLE);
    assign op_done    = (r_state == c_ST_FIN);
    assign op_error   = (r_state == c_ST_FIN) && r_err;
    assign xfer_valid = w_issuing && !r_issued;

    always_comb begin
        xfer_cmd = 5'd0;
        case (r_state)
            c_ST_WREN:  xfer_cmd = c_CMD_WREN;
            c_ST_OP:    xfer_cmd = r_cmd_q;
            c_ST_POLL:  xfer_cmd = c_CMD_RDSR;
            c_ST_RSTEN: xfer_cmd = c_CMD_RST_EN;
            c_ST_RST:   xfer_cmd = c_CMD_RST;
            default:    xfer_cmd = 5'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_ST_IDLE;
            r_cmd_q    <= 5'd0;
            r_issued   <= 1'b0;
            r_poll_cnt <= 20'd0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_err    <= 1'b0;
                    r_issued <= 1'b0;
                    if (req_valid) begin
                        r_cmd_q <= req_cmd;
                        case (op_class(req_cmd))
                            OPC_WRITE: r_state <= c_ST_WREN;
                            OPC_RESET: r_state <= c_ST_RSTEN;
                            default:   r_state <= c_ST_OP;
                        endcase
                    end
                end
                c_ST_FIN: begin
                    r_state <= c_ST_IDLE;
                    r_err   <= 1'b0;
                end
                c_ST_WREN, c_ST_OP, c_ST_POLL, c_ST_RSTEN, c_ST_RST: begin
                    if (w_xfer_complete) begin
                        r_issued <= 1'b0;
                        case (r_state)
                            c_ST_WREN:  r_state <= c_ST_OP;
                            c_ST_OP: begin
                                if (op_class(r_cmd_q) == OPC_WRITE) begin
                                    r_state    <= c_ST_POLL;
                                    r_poll_cnt <= 20'd0;
                                end else begin
                                    r_state <= c_ST_FIN;
                                end
                            end
                            c_ST_POLL: begin
                                // Exit before the counter could ever wrap.
                                if (!w_wip) begin
                                    r_state <= c_ST_FIN;
                                end else if (w_poll_next >= POLL_MAX) begin
                                    r_state <= c_ST_FIN;
                                    r_err   <= 1'b1;
                                end else begin
                                    r_poll_cnt <= w_poll_next;
                                end
                            end
                            c_ST_RSTEN: r_state <= c_ST_RST;
                            default:    r_state <= c_ST_FIN;
                        endcase
                    end else if (!r_issued && xfer_ready) begin
                        r_issued <= 1'b1;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_flash_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_flash_op_sequencer
// Description : Directed self-checking bench for flash_op_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flash_op_sequencer;
    import flash_op_sequencer_pkg::*;

    logic       clk;
    logic       reset;
    logic       req_valid;
    logic [4:0] req_cmd;
    logic       req_ready;
    logic       op_done;
    logic       op_error;
    logic       xfer_valid;
    logic [4:0] xfer_cmd;
    logic       xfer_ready;
    logic       xfer_done;
    logic [7:0] xfer_status;

    // Engine model: auto mode accepts and completes in the issuing cycle.
    logic       eng_auto;
    logic       man_ready;
    logic       man_done;
    logic [7:0] stat_seq [0:7];
    logic [3:0] stat_n;
    logic [7:0] stat_fill;
    logic [3:0] stat_idx;

    logic       clr;
    logic [4:0] log_cmd [0:15];
    int         log_n;
    int         done_cnt;
    logic       last_err;

    int n_vec;
    int n_err;

    flash_op_sequencer #(
        .POLL_MAX (20'd4),
        .WIP_BIT  (0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_cmd     (req_cmd),
        .req_ready   (req_ready),
        .op_done     (op_done),
        .op_error    (op_error),
        .xfer_valid  (xfer_valid),
        .xfer_cmd    (xfer_cmd),
        .xfer_ready  (xfer_ready),
        .xfer_done   (xfer_done),
        .xfer_status (xfer_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign xfer_ready  = eng_auto ? xfer_valid : man_ready;
    assign xfer_done   = eng_auto ? xfer_valid : man_done;
    assign xfer_status = (stat_idx < stat_n) ? stat_seq[stat_idx[2:0]] : stat_fill;

    always @(posedge clk) begin
        if (clr) begin
            log_n    <= 0;
            done_cnt <= 0;
            last_err <= 1'b0;
            stat_idx <= 4'd0;
        end else begin
            if (xfer_valid && xfer_ready && log_n < 16) begin
                log_cmd[log_n[3:0]] <= xfer_cmd;
                log_n <= log_n + 1;
            end
            if (xfer_done && xfer_cmd == c_CMD_RDSR && stat_idx != 4'hF)
                stat_idx <= stat_idx + 4'd1;
            if (op_done) begin
                done_cnt <= done_cnt + 1;
                last_err <= op_error;
            end
        end
    end

    task automatic check_value(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic run_op(input logic [4:0] cmd, input int budget);
        int cyc;
        req_valid = 1'b1;
        req_cmd   = cmd;
        tick();
        req_valid = 1'b0;
        cyc = 0;
        while (done_cnt == 0 && cyc < budget) begin
            tick();
            cyc++;
        end
        if (done_cnt == 0) check_value("op_timeout", 32'(cyc), 32'(budget + 1));
        tick();
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        reset = 1'b1; req_valid = 1'b0; req_cmd = 5'd0;
        eng_auto = 1'b1; man_ready = 1'b0; man_done = 1'b0;
        stat_n = 4'd0; stat_fill = 8'h00; clr = 1'b1;
        for (int i = 0; i < 8; i++) stat_seq[i] = 8'h00;
        tick(); tick();
        check_value("rst_req_ready",  32'(req_ready),  32'd1);
        check_value("rst_xfer_valid", 32'(xfer_valid), 32'd0);
        check_value("rst_op_done",    32'(op_done),    32'd0);
        check_value("rst_op_error",   32'(op_error),   32'd0);
        check_value("rst_xfer_cmd",   32'(xfer_cmd),   32'd0);
        reset = 1'b0;
        clr = 1'b0;
        clear_log();

        // SIMPLE JEDEC with immediate engine: accept, OP, FIN
        req_valid = 1'b1; req_cmd = c_CMD_JEDEC;
        tick();
        req_valid = 1'b0;
        check_value("jedec_valid",   32'(xfer_valid), 32'd1);
        check_value("jedec_cmd",     32'(xfer_cmd),   32'(c_CMD_JEDEC));
        check_value("jedec_nodone",  32'(op_done),    32'd0);
        tick();
        check_value("jedec_done",    32'(op_done),    32'd1);
        check_value("jedec_err",     32'(op_error),   32'd0);
        check_value("jedec_busy",    32'(req_ready),  32'd0);
        tick();
        check_value("jedec_idle",    32'(req_ready),  32'd1);
        check_value("jedec_pulse",   32'(op_done),    32'd0);
        check_value("jedec_nxfer",   32'(log_n),      32'd1);
        check_value("jedec_log0",    32'(log_cmd[0]), 32'(c_CMD_JEDEC));

        // PP with WIP clearing on the third poll
        clear_log();
        stat_seq[0] = 8'h01; stat_seq[1] = 8'h01; stat_seq[2] = 8'h00;
        stat_n = 4'd3; stat_fill = 8'h00;
        run_op(c_CMD_PP, 30);
        check_value("pp_nxfer", 32'(log_n), 32'd5);
        check_value("pp_log0",  32'(log_cmd[0]), 32'(c_CMD_WREN));
        check_value("pp_log1",  32'(log_cmd[1]), 32'(c_CMD_PP));
        check_value("pp_log2",  32'(log_cmd[2]), 32'(c_CMD_RDSR));
        check_value("pp_log4",  32'(log_cmd[4]), 32'(c_CMD_RDSR));
        check_value("pp_ndone", 32'(done_cnt), 32'd1);
        check_value("pp_err",   32'(last_err), 32'd0);

        // SE with WIP stuck: POLL_MAX=4 polls then error
        clear_log();
        stat_n = 4'd0; stat_fill = 8'h01;
        run_op(c_CMD_SE, 30);
        check_value("se_nxfer", 32'(log_n), 32'd6);
        check_value("se_log1",  32'(log_cmd[1]), 32'(c_CMD_SE));
        check_value("se_log5",  32'(log_cmd[5]), 32'(c_CMD_RDSR));
        check_value("se_ndone", 32'(done_cnt), 32'd1);
        check_value("se_err",   32'(last_err), 32'd1);
        check_value("se_errlow", 32'(op_error), 32'd0);

        // RST: RST_EN then RST, no RDSR
        clear_log();
        run_op(c_CMD_RST, 30);
        check_value("rst_nxfer", 32'(log_n), 32'd2);
        check_value("rst_log0",  32'(log_cmd[0]), 32'(c_CMD_RST_EN));
        check_value("rst_log1",  32'(log_cmd[1]), 32'(c_CMD_RST));
        check_value("rst_ndone", 32'(done_cnt), 32'd1);
        check_value("rst_err",   32'(last_err), 32'd0);

        // Reset during POLL, then a late xfer_done
        clear_log();
        stat_n = 4'd0; stat_fill = 8'h01;
        req_valid = 1'b1; req_cmd = c_CMD_CE;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 10 && xfer_cmd != c_CMD_RDSR; i++) tick();
        check_value("mid_in_poll", 32'(xfer_cmd), 32'(c_CMD_RDSR));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_value("mid_ready", 32'(req_ready),  32'd1);
        check_value("mid_valid", 32'(xfer_valid), 32'd0);
        check_value("mid_done",  32'(op_done),    32'd0);
        eng_auto = 1'b0; man_ready = 1'b0; man_done = 1'b1;
        tick();
        man_done = 1'b0;
        check_value("late_ready", 32'(req_ready),  32'd1);
        check_value("late_valid", 32'(xfer_valid), 32'd0);
        tick();
        check_value("late_ndone", 32'(done_cnt), 32'd0);

        // Engine stall in OP with ignored requests and early done
        clear_log();
        req_valid = 1'b1; req_cmd = c_CMD_READ;
        tick();
        for (int i = 0; i < 5; i++) begin
            check_value("stall_valid", 32'(xfer_valid), 32'd1);
            check_value("stall_cmd",   32'(xfer_cmd),   32'(c_CMD_READ));
            check_value("stall_busy",  32'(req_ready),  32'd0);
            req_valid = (i % 2 == 0);
            req_cmd   = c_CMD_CE;
            man_done  = (i == 2);
            tick();
        end
        req_valid = 1'b0; man_done = 1'b0;
        check_value("stall_hold", 32'(xfer_valid), 32'd1);
        man_ready = 1'b1;
        tick();
        man_ready = 1'b0;
        check_value("wait_valid", 32'(xfer_valid), 32'd0);
        check_value("wait_nodone", 32'(op_done),   32'd0);
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
        check_value("stall_done", 32'(op_done),  32'd1);
        check_value("stall_err",  32'(op_error), 32'd0);
        tick();
        check_value("stall_idle",  32'(req_ready),  32'd1);
        check_value("stall_noq",   32'(xfer_valid), 32'd0);
        check_value("stall_nxfer", 32'(log_n),      32'd1);
        check_value("stall_ndone", 32'(done_cnt),   32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
